// File: rtl/ppi_bus_master.sv
// Host-side initiator for an 8255A-style peripheral bus: one register access per
// valid/ready handshake, with programmable setup, strobe, hold and recovery times.
module ppi_bus_master #(
  parameter int unsigned T_SETUP  = 2,
  parameter int unsigned T_STROBE = 4,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned T_RECOV  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       nCS,
  output logic       nRD,
  output logic       nWR,
  output logic [1:0] A,
  output logic [7:0] Dout,
  input  logic [7:0] Din,
  output logic       DEn
);

  generate
    if (T_SETUP  < 1 || T_SETUP  > 15 || T_STROBE < 1 || T_STROBE > 15 ||
        T_HOLD   < 1 || T_HOLD   > 15 || T_RECOV  < 1 || T_RECOV  > 15) begin : g_bad_param
      $error("ppi_bus_master: timing parameters must lie in 1..15");
    end
  endgenerate

  localparam logic [3:0] LD_SETUP  = 4'(T_SETUP  - 1);
  localparam logic [3:0] LD_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] LD_HOLD   = 4'(T_HOLD   - 1);
  localparam logic [3:0] LD_RECOV  = 4'(T_RECOV  - 1);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOV} state_t;

  state_t     state, next_state;
  logic [3:0] cnt, next_cnt;
  logic       rw_q;
  logic       accept;
  logic       next_rw;
  logic       next_in_cycle;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_ready & req_valid;

  // The bus outputs are registered from the next-state view, so the request
  // fields must be taken straight from the inputs on the accepting edge.
  assign next_rw       = accept ? req_rw : rw_q;
  assign next_in_cycle = (next_state == SETUP) || (next_state == STROBE) || (next_state == HOLD);

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = SETUP;
          next_cnt   = LD_SETUP;
        end
      end
      SETUP: begin
        if (cnt == 4'd0) begin
          next_state = STROBE;
          next_cnt   = LD_STROBE;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      STROBE: begin
        if (cnt == 4'd0) begin
          next_state = HOLD;
          next_cnt   = LD_HOLD;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      HOLD: begin
        if (cnt == 4'd0) begin
          next_state = RECOV;
          next_cnt   = LD_RECOV;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      RECOV: begin
        if (cnt == 4'd0) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else begin
          next_cnt = cnt - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rw_q  <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) rw_q <= req_rw;
    end
  end

  // Async reset releases the bus at once; an access in flight is discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nCS       <= 1'b1;
      nRD       <= 1'b1;
      nWR       <= 1'b1;
      DEn       <= 1'b0;
      A         <= 2'd0;
      Dout      <= 8'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'd0;
    end else begin
      nCS       <= ~next_in_cycle;
      nRD       <= ~((next_state == STROBE) &  next_rw);
      nWR       <= ~((next_state == STROBE) & ~next_rw);
      DEn       <= next_in_cycle & ~next_rw;
      rsp_valid <= (state == HOLD) && (next_state == RECOV);
      if (accept) A <= req_addr;
      if (accept && !req_rw) Dout <= req_wdata;
      // Capture on the edge closing the last low strobe cycle.
      if ((state == STROBE) && (cnt == 4'd0) && rw_q) rsp_rdata <= Din;
    end
  end

endmodule

// File: tb/tb_ppi_bus_master.sv
// Scoreboard bench for ppi_bus_master: directed accesses push expected read data,
// a monitor pops on rsp_valid; bus waveforms are checked cycle by cycle.
module tb_ppi_bus_master;
  localparam int S   = 2;
  localparam int ST  = 4;
  localparam int H   = 1;
  localparam int R   = 2;
  localparam int CYC = S + ST + H;
  localparam int N   = CYC + R;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_rw = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'd0, din = 8'd0;
  logic       req_ready, rsp_valid, busy, ncs, nrd, nwr, den;
  logic [7:0] rsp_rdata, dout;
  logic [1:0] a;

  logic       f_req_valid = 1'b0;
  logic       f_req_ready, f_rsp_valid, f_busy, f_ncs, f_nrd, f_nwr, f_den;
  logic [7:0] f_rsp_rdata, f_dout;
  logic [1:0] f_a;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_rd = 8'd0;
  logic [7:0] mon_exp;

  ppi_bus_master u_dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .nCS(ncs), .nRD(nrd), .nWR(nwr), .A(a), .Dout(dout), .Din(din), .DEn(den)
  );

  ppi_bus_master #(.T_SETUP(1), .T_STROBE(1), .T_HOLD(1), .T_RECOV(1)) u_fast (
    .clk(clk), .reset(rst),
    .req_valid(f_req_valid), .req_ready(f_req_ready), .req_rw(1'b0),
    .req_addr(2'd3), .req_wdata(8'h3C),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .nCS(f_ncs), .nRD(f_nrd), .nWR(f_nwr), .A(f_a), .Dout(f_dout), .Din(8'h00), .DEn(f_den)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp_valid", rsp_valid, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_exp);
      end
    end
  end

  // One full access on the default-timing DUT; called at a negedge.
  task automatic access(input logic rw, input logic [1:0] addr, input logic [7:0] wd,
                        input logic [7:0] d_early, input logic [7:0] d_last,
                        input logic [7:0] d_hold, input bit keep, output time t_acc);
    int   w;
    bit   in_c, strb;
    logic [7:0] e;
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd; din = d_early;
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait_in_budget", (w < 40), 1);
    @(posedge clk);
    t_acc = $time;
    e = rw ? d_last : last_rd;
    exp_q.push_back(e);
    last_rd = e;
    for (int k = 1; k <= N; k++) begin
      @(negedge clk);
      if (!keep && k == 1) req_valid = 1'b0;
      din  = (k < S + ST) ? d_early : ((k == S + ST) ? d_last : d_hold);
      in_c = (k <= CYC);
      strb = (k > S) && (k <= S + ST);
      check($sformatf("ncs_c%0d", k), ncs, !in_c);
      check($sformatf("nwr_c%0d", k), nwr, !(strb && !rw));
      check($sformatf("nrd_c%0d", k), nrd, !(strb && rw));
      check($sformatf("den_c%0d", k), den, in_c && !rw);
      check($sformatf("rsp_valid_c%0d", k), rsp_valid, (k == CYC + 1));
      check($sformatf("req_ready_c%0d", k), req_ready, 0);
      check($sformatf("busy_c%0d", k), busy, 1);
      if (in_c) check($sformatf("addr_c%0d", k), a, addr);
      if (in_c && !rw) check($sformatf("dout_c%0d", k), dout, wd);
    end
  endtask

  time t1, t2, t3, t_dummy;
  int  acc[$];
  int  ncs_low, nwr_low, nrd_low;

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ncs", ncs, 1);
    check("rst_nrd", nrd, 1);
    check("rst_nwr", nwr, 1);
    check("rst_a", a, 0);
    check("rst_dout", dout, 0);
    check("rst_den", den, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // Control-word write, then a read of port B.
    access(1'b0, 2'd3, 8'h80, 8'h00, 8'h00, 8'h00, 1'b0, t_dummy);
    @(negedge clk);
    access(1'b1, 2'd1, 8'h00, 8'hA5, 8'hA5, 8'hA5, 1'b0, t_dummy);
    @(negedge clk);

    // Back-to-back with req_valid held high.
    access(1'b0, 2'd2, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b1, t1);
    access(1'b1, 2'd0, 8'h00, 8'h3C, 8'h3C, 8'h3C, 1'b1, t2);
    access(1'b0, 2'd1, 8'hC3, 8'h00, 8'h00, 8'h00, 1'b0, t3);
    check("b2b_gap_1", 32'((t2 - t1) / 10), N + 1);
    check("b2b_gap_2", 32'((t3 - t2) / 10), N + 1);
    @(negedge clk);

    // Din changes in the last strobe cycle versus during HOLD.
    access(1'b1, 2'd2, 8'h00, 8'h11, 8'h22, 8'h22, 1'b0, t_dummy);
    @(negedge clk);
    access(1'b1, 2'd2, 8'h00, 8'h11, 8'h11, 8'h22, 1'b0, t_dummy);
    @(negedge clk);

    // Reset in the first STROBE cycle of a write.
    req_valid = 1'b1; req_rw = 1'b0; req_addr = 2'd2; req_wdata = 8'hF0;
    check("pre_reset_ready", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (S) @(negedge clk);
    check("pre_reset_nwr_low", nwr, 0);
    rst = 1'b1;
    #1;
    check("mid_reset_nwr", nwr, 1);
    check("mid_reset_ncs", ncs, 1);
    check("mid_reset_den", den, 0);
    check("mid_reset_busy", busy, 0);
    check("mid_reset_rsp_rdata", rsp_rdata, 0);
    last_rd = 8'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("queue_empty_after_reset", exp_q.size(), 0);
    access(1'b1, 2'd0, 8'h00, 8'h77, 8'h77, 8'h77, 1'b0, t_dummy);
    repeat (3) @(negedge clk);

    // All timing parameters at 1, req_valid held.
    ncs_low = 0; nwr_low = 0; nrd_low = 0;
    f_req_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (f_req_ready) acc.push_back(c);
      if (!f_ncs) ncs_low++;
      if (!f_nwr) nwr_low++;
      if (!f_nrd) nrd_low++;
      @(negedge clk);
    end
    f_req_valid = 1'b0;
    check("fast_accepts", acc.size(), 3);
    if (acc.size() >= 3) begin
      check("fast_period_1", acc[1] - acc[0], 5);
      check("fast_period_2", acc[2] - acc[1], 5);
    end
    check("fast_ncs_low_cycles", ncs_low, 9);
    check("fast_nwr_low_cycles", nwr_low, 3);
    check("fast_nrd_low_cycles", nrd_low, 0);

    repeat (4) @(negedge clk);
    check("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
